// File: rtl/heartbeat_kicker.sv
// -----------------------------------------------------------------------------
// heartbeat_kicker
//
// Drives the heartbeat input of watchdog_timer. Alive strobes from the monitored
// subsystems are collected over a fixed window of PERIOD cycles. At the end of
// each window the collected set is evaluated:
//   - If every monitored source checked in, a PULSE_LEN-cycle heartbeat is issued.
//   - Otherwise the window counts as missed.
// After MAX_MISS consecutive missed windows the kicker stops pulsing on purpose.
// The watchdog is then left to warn and trigger. Only enable=0 or reset ends
// this starving condition.
//
// Ports
//   clk          in   1      system clock
//   rstn         in   1      asynchronous active-low reset
//   enable       in   1      run kicker; low = idle and clear window state
//   src_mask     in   N_SRC  1 = source monitored, applied at window evaluation
//   src_alive    in   N_SRC  single-cycle check-in strobes
//   heartbeat    out  1      registered pulse to watchdog_timer.heartbeat
//   missed_mask  out  N_SRC  monitored sources absent in last evaluated window
//   miss_count   out  8      total missed windows, saturating at 255
//   starving     out  1      high while heartbeats are deliberately withheld
// -----------------------------------------------------------------------------
module heartbeat_kicker #(
    parameter int N_SRC     = 4,
    parameter int PERIOD    = 1000,
    parameter int PULSE_LEN = 2,
    parameter int MAX_MISS  = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [N_SRC-1:0] src_mask,
    input  logic [N_SRC-1:0] src_alive,
    output logic             heartbeat,
    output logic [N_SRC-1:0] missed_mask,
    output logic [7:0]       miss_count,
    output logic             starving
);

    localparam int CW = $clog2(PERIOD);
    localparam int KW = $clog2(MAX_MISS + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [KW-1:0] MISS_LIMIT = KW'(MAX_MISS);
    localparam logic [KW-1:0] STARVE_AT  = KW'(MAX_MISS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_KICK,
        S_STARVE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_SRC-1:0] seen_q, seen_d;
    logic [N_SRC-1:0] missed_q, missed_d;
    logic [7:0]       miss_cnt_q, miss_cnt_d;
    logic [KW-1:0]    consec_q, consec_d;
    logic             hb_q, hb_d;
    logic             starve_q, starve_d;

    logic [N_SRC-1:0] seen_eval;
    logic             boundary;
    logic             hit;

    // A strobe on the boundary cycle still belongs to the closing window.
    // That is why evaluation uses seen_q merged with this cycle's strobes.
    assign seen_eval = seen_q | (src_alive & src_mask);
    assign boundary  = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
    // An empty mask is trivially satisfied and counts as a hit.
    assign hit       = ((seen_eval & src_mask) == src_mask);

    // NOTE: every variable driven here gets a default first.
    // A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        missed_d   = missed_q;
        miss_cnt_d = miss_cnt_q;
        consec_d   = consec_q;

        if (!enable) begin
            // miss_count and missed_mask deliberately keep their values here.
            state_d  = S_IDLE;
            cnt_d    = '0;
            seen_d   = '0;
            consec_d = '0;
        end else if (state_q == S_IDLE) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
            seen_d  = '0;
        end else if (boundary) begin
            cnt_d  = '0;
            seen_d = '0;
            if (hit) begin
                missed_d = '0;
                consec_d = '0;
                // While starving, a hit is recorded but never produces a pulse.
                if (state_q != S_STARVE) begin
                    state_d = S_KICK;
                end
            end else begin
                missed_d = src_mask & ~seen_eval;
                if (miss_cnt_q != 8'hFF) begin
                    miss_cnt_d = miss_cnt_q + 8'd1;
                end
                if (consec_q != MISS_LIMIT) begin
                    consec_d = consec_q + 1'b1;
                end
                // consec_q is the count before this miss.
                // Reaching STARVE_AT means this miss is number MAX_MISS.
                if (consec_q >= STARVE_AT) begin
                    state_d = S_STARVE;
                end else if (state_q != S_STARVE) begin
                    state_d = S_COLLECT;
                end
            end
        end else begin
            cnt_d  = cnt_q + 1'b1;
            seen_d = seen_eval;
            // KICK covers window counts 0..PULSE_LEN-1.
            // PULSE_LEN <= PERIOD-2, so it always ends before the next boundary.
            if ((state_q == S_KICK) && (cnt_q == PULSE_LAST)) begin
                state_d = S_COLLECT;
            end
        end

        // Outputs come from dedicated flops fed by the next state.
        // They are therefore glitch-free and change in the same cycle as the state.
        hb_d     = (state_d == S_KICK);
        starve_d = (state_d == S_STARVE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // All flops then update together from the values held before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            seen_q     <= '0;
            missed_q   <= '0;
            miss_cnt_q <= '0;
            consec_q   <= '0;
            hb_q       <= 1'b0;
            starve_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_q     <= seen_d;
            missed_q   <= missed_d;
            miss_cnt_q <= miss_cnt_d;
            consec_q   <= consec_d;
            hb_q       <= hb_d;
            starve_q   <= starve_d;
        end
    end

    assign heartbeat   = hb_q;
    assign starving    = starve_q;
    assign missed_mask = missed_q;
    assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_heartbeat_kicker.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_kicker
//
// Testbench for heartbeat_kicker with a short window (PERIOD=8).
//   - A table of per-cycle vectors covers a hit window and then a missed window.
//   - Hand-written sequences cover starving, boundary strobes, an empty mask,
//     mid-pulse reset and saturation of miss_count.
//   - Random stimulus is compared every cycle against a window-level reference model.
// -----------------------------------------------------------------------------
module tb_heartbeat_kicker;

    localparam int N_SRC     = 4;
    localparam int PERIOD    = 8;
    localparam int PULSE_LEN = 2;
    localparam int MAX_MISS  = 3;

    logic             clk;
    logic             rstn;
    logic             enable;
    logic [N_SRC-1:0] src_mask;
    logic [N_SRC-1:0] src_alive;
    logic             heartbeat;
    logic [N_SRC-1:0] missed_mask;
    logic [7:0]       miss_count;
    logic             starving;

    int checks = 0;
    int errors = 0;

    heartbeat_kicker #(
        .N_SRC    (N_SRC),
        .PERIOD   (PERIOD),
        .PULSE_LEN(PULSE_LEN),
        .MAX_MISS (MAX_MISS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .src_mask   (src_mask),
        .src_alive  (src_alive),
        .heartbeat  (heartbeat),
        .missed_mask(missed_mask),
        .miss_count (miss_count),
        .starving   (starving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (window bookkeeping) ----------------
    bit               m_active;
    int               m_pos;
    logic [N_SRC-1:0] m_seen;
    int               m_consec;
    bit               m_starve;
    int               m_pulse;   // remaining heartbeat cycles
    logic [N_SRC-1:0] m_missed;
    int               m_cnt;

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_seen = '0; m_consec = 0;
        m_starve = 0; m_pulse = 0; m_missed = '0; m_cnt = 0;
    endtask

    task automatic model_step(input logic en, input logic [N_SRC-1:0] mask,
                              input logic [N_SRC-1:0] alive);
        logic [N_SRC-1:0] ev;
        if (!en) begin
            m_active = 0; m_pos = 0; m_seen = '0; m_consec = 0;
            m_starve = 0; m_pulse = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0; m_seen = '0; m_pulse = 0;
        end else begin
            ev = m_seen | (alive & mask);
            if (m_pulse > 0) m_pulse--;
            if (m_pos == PERIOD - 1) begin
                m_pos  = 0;
                m_seen = '0;
                if ((ev & mask) == mask) begin
                    m_missed = '0;
                    m_consec = 0;
                    if (!m_starve) m_pulse = PULSE_LEN;
                end else begin
                    m_missed = mask & ~ev;
                    if (m_cnt < 255) m_cnt++;
                    m_consec++;
                    if (m_consec >= MAX_MISS) m_starve = 1;
                end
            end else begin
                m_pos++;
                m_seen = ev;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, settle, advance the model.
    task automatic tick(input logic en, input logic [N_SRC-1:0] mask,
                        input logic [N_SRC-1:0] alive);
        enable    = en;
        src_mask  = mask;
        src_alive = alive;
        @(posedge clk);
        #1;
        if (!rstn) model_reset();
        else       model_step(en, mask, alive);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick(1'b0, '0, '0);
        tick(1'b0, '0, '0);
        rstn = 1'b1;
        model_reset();
    endtask

    // Runs one full window starting at window count 0 with enable held high.
    // saw_hb records any heartbeat seen before the closing boundary.
    task automatic run_window(input logic [N_SRC-1:0] mask, input logic [N_SRC-1:0] a_first,
                              input logic [N_SRC-1:0] a_last, output logic saw_hb);
        saw_hb = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            tick(1'b1, mask, (k == 0) ? a_first : ((k == PERIOD - 1) ? a_last : '0));
            if (k < PERIOD - 1) saw_hb |= heartbeat;
        end
    endtask

    typedef struct {
        logic             en;
        logic [N_SRC-1:0] mask;
        logic [N_SRC-1:0] alive;
        logic             hb;
        logic             st;
        logic [N_SRC-1:0] missed;
        logic [7:0]       cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic saw;
        logic [N_SRC-1:0] rmask;
        logic             ren;

        rstn = 1'b0; enable = 1'b0; src_mask = '0; src_alive = '0;
        model_reset();

        // Table: entry c holds inputs driven during COLLECT cycle c
        // (c=-1 is the IDLE cycle) and the outputs expected in cycle c+1.
        // Window 0 is a hit: src0 strobes at c2 and src1 at c5, so heartbeat is high in cycles 8-9.
        // Window 1 is a miss: only src0 strobes.
        for (int c = -1; c <= 15; c++) begin
            v.en     = 1'b1;
            v.mask   = 4'b0011;
            v.alive  = (c == 2 || c == 10) ? 4'b0001 : ((c == 5) ? 4'b0010 : 4'b0000);
            v.hb     = (c == 7 || c == 8);
            v.st     = 1'b0;
            v.missed = (c >= 15) ? 4'b0010 : 4'b0000;
            v.cnt    = (c >= 15) ? 8'd1 : 8'd0;
            vecs.push_back(v);
        end

        // 1: reset held for three cycles with random inputs
        for (int i = 0; i < 3; i++) tick($urandom_range(0, 1), 4'($urandom), 4'($urandom));
        check("rst_hb", heartbeat, 0);
        check("rst_starving", starving, 0);
        check("rst_missed", missed_mask, 0);
        check("rst_count", miss_count, 0);
        rstn = 1'b1;
        model_reset();

        // 2 + 3: table-driven hit window followed by a missed window
        tick(1'b0, '0, '0);
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].en, vecs[i].mask, vecs[i].alive);
            check($sformatf("vec%0d_hb", i), heartbeat, vecs[i].hb);
            check($sformatf("vec%0d_st", i), starving, vecs[i].st);
            check($sformatf("vec%0d_missed", i), missed_mask, vecs[i].missed);
            check($sformatf("vec%0d_cnt", i), miss_count, vecs[i].cnt);
        end

        // 4: three missed windows lead to starving; hits then stay silent; enable clears it
        do_reset();
        tick(1'b1, 4'b0011, '0);
        run_window(4'b0011, '0, '0, saw);
        check("miss1_st", starving, 0);
        run_window(4'b0011, '0, '0, saw);
        check("miss2_st", starving, 0);
        run_window(4'b0011, '0, '0, saw);
        check("miss3_st", starving, 1);
        check("miss3_cnt", miss_count, 3);
        check("miss3_missed", missed_mask, 4'b0011);
        run_window(4'b0011, 4'b0011, '0, saw);
        check("starve_hit_hb", heartbeat, 0);
        check("starve_hit_missed", missed_mask, 0);
        tick(1'b1, 4'b0011, '0);
        check("starve_hit_hb_next", heartbeat, 0);
        check("starve_hold", starving, 1);
        tick(1'b0, 4'b0011, '0);
        check("disable_st", starving, 0);
        check("disable_cnt_hold", miss_count, 3);
        tick(1'b1, 4'b0011, '0);
        run_window(4'b0011, 4'b0011, '0, saw);
        check("reenable_hb", heartbeat, 1);
        check("reenable_st", starving, 0);

        // 5: strobes on the boundary and on count 0 count for the right windows
        do_reset();
        tick(1'b1, 4'b0011, '0);
        run_window(4'b0011, 4'b0001, 4'b0010, saw);
        check("bnd_strobe_hb", heartbeat, 1);
        check("bnd_strobe_missed", missed_mask, 0);
        run_window(4'b0011, 4'b0010, 4'b0001, saw);
        check("cnt0_strobe_hb", heartbeat, 1);
        run_window(4'b0011, 4'b0001, '0, saw);
        check("no_carry_hb", heartbeat, 0);
        check("no_carry_missed", missed_mask, 4'b0010);
        check("no_carry_cnt", miss_count, 1);
        run_window(4'b0000, '0, '0, saw);
        check("empty_mask_hb", heartbeat, 1);
        check("empty_mask_missed", missed_mask, 0);

        // 6: reset during the first heartbeat cycle clears it without a clock edge
        do_reset();
        tick(1'b1, 4'b0011, '0);
        run_window(4'b0011, 4'b0011, '0, saw);
        check("pre_rst_hb", heartbeat, 1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_hb", heartbeat, 0);
        model_reset();
        tick(1'b1, 4'b0011, 4'b0011);
        rstn = 1'b1;
        tick(1'b1, 4'b0011, '0);
        run_window(4'b0011, 4'b0011, '0, saw);
        check("post_rst_no_early_hb", saw, 0);
        check("post_rst_hb", heartbeat, 1);

        // miss_count saturates at 255
        do_reset();
        tick(1'b1, 4'b0001, '0);
        for (int w = 0; w < 260; w++) run_window(4'b0001, '0, '0, saw);
        check("sat_cnt", miss_count, 255);
        check("sat_st", starving, 1);

        // Random stimulus checked every cycle against the reference model
        do_reset();
        rmask = 4'b0111;
        for (int i = 0; i < 2500; i++) begin
            ren = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 19) == 0) rmask = 4'($urandom);
            tick(ren, rmask, 4'($urandom & $urandom));
            check("rand_hb", heartbeat, (m_pulse > 0));
            check("rand_st", starving, m_starve);
            check("rand_missed", missed_mask, m_missed);
            check("rand_cnt", miss_count, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
